cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Collects completed results from the functional units (FUs) and drives the common data bus (CDB) packet: one tag/value per cycle.
- That packet is consumed by the map table (tag clear), the reservation stations and the ROB.
- Each FU has a one-entry holding register. A round-robin arbiter picks one full holding register per cycle and registers it onto the CDB.
- A per-FU ready handshake back-pressures FUs that lose arbitration.

Parameters:
- NUM_FU, 4: number of FU completion ports (2..8).
- TAG_W, 4: RS tag width. Tag 0 is the reserved "no tag" value (ZERO_REG).
- XLEN, 32: result value width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clock edge)
- flush  in  1  squash: discard all held and outgoing results
- fu_valid  in  NUM_FU  FU i presents a completed result
- fu_tag  in  NUM_FU*TAG_W  RS tag of FU i's result (slice i)
- fu_value  in  NUM_FU*XLEN  result value of FU i (slice i)
- fu_ready  out  NUM_FU  holding register i can accept this cycle
- cdb_valid  out  1  CDB carries a valid broadcast
- cdb_tag  out  TAG_W  broadcast tag; 0 when cdb_valid=0
- cdb_value  out  XLEN  broadcast value; 0 when cdb_valid=0

Behaviour:
- Handshake:
  - Transfer on FU i occurs in a cycle with fu_valid[i] && fu_ready[i].
  - fu_ready[i] = !hold_valid[i] || grant[i] (combinational).
  - The FU holds tag/value stable while valid && !ready.
- Capture: on transfer, hold_valid[i], hold_tag[i] and hold_value[i] load at the clock edge.
  - fu_valid with fu_tag==0 is dropped: fu_ready still applies, nothing is stored.
- Arbitration (combinational, each cycle):
  - Among hold_valid, grant the first index ≥ rr_ptr, wrapping modulo NUM_FU. At most one grant.
- Broadcast (at the clock edge when a grant exists):
  - cdb_valid<=1; cdb_tag/cdb_value <= granted holding entry.
  - hold_valid[grant] is cleared unless a new transfer on the same port reloads it in the same cycle (back-to-back allowed).
  - rr_ptr <= (grant+1) mod NUM_FU.
- No grant: cdb_valid<=0, cdb_tag<=0, cdb_value<=0; rr_ptr unchanged.
- Latency: transfer in cycle N → earliest cdb_valid in cycle N+2.
- Throughput: one broadcast per cycle sustained. A single FU sustains one result per cycle.
- Fairness: with all NUM_FU holdings full, every FU is broadcast within NUM_FU cycles.
- Flush:
  - At the edge: all hold_valid<=0; cdb_valid/tag/value<=0.
  - Transfers in the flush cycle are discarded.
  - fu_ready is forced to all-ones during flush.
  - rr_ptr is unchanged.
- Reset (reset==0 at edge): hold_valid=0, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_value=0.
  - fu_ready reads all-ones after reset.
  - Reset mid-operation loses all pending results.
- Reset has priority over flush; flush has priority over capture and broadcast.

Optional Feature:
- Macro: CDB_ARB_BYPASS_EN.
- Defined:
  - In a cycle with no hold_valid set and no flush, an incoming transfer competes directly in round-robin order, using the same rr_ptr rule.
  - The winner is broadcast at that edge without being stored, giving cycle N+1 latency.
  - Losers are captured normally.
- Undefined: all results pass through the holding registers; latency is fixed at N+2 minimum.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release → cdb_valid=0, cdb_tag=0, fu_ready=4'b1111.
- Single result: FU1 valid, tag=3, value=32'hDEAD_BEEF in cycle 5 → cdb_valid=1, tag=3, value=DEADBEEF in cycle 7 only (cycle 6 with bypass).
- Round-robin: all 4 FUs valid in cycle 5 with tags 1,2,3,4; rr_ptr=0.
  - → broadcasts tag 1,2,3,4 in cycles 7–10.
  - fu_ready[3]=0 in cycles 6–8 (waiting for grant) if FU3 re-asserts valid.
  - Next contention starts at FU0.
- Back-pressure: FU2 valid every cycle while FU0 holding is full.
  - → FU0 and FU2 alternate on the CDB.
  - No tag lost or duplicated; scoreboard of 16 results matches.
- Flush: flush=1 while FUs 0 and 2 hold tags 5 and 6 → cdb_valid=0 the following cycle; tags 5 and 6 never appear.
- Tag 0 drop: FU3 valid with tag=0 → no broadcast ever occurs; fu_ready[3] stays 1.

Source files
------------

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Collects completed results from NUM_FU functional units, keeps
//             one holding register per FU, and broadcasts one tag/value per
//             cycle on the common data bus (CDB).
//
//             A round-robin arbiter selects the holding register to send.
//             A per-FU ready handshake back-pressures units that lose
//             arbitration.
//
//             Tag 0 means "no tag". A result that carries tag 0 is accepted
//             but never stored or broadcast.
//
//  Option   : `define CDB_ARB_BYPASS_EN
//             When every holding register is empty, incoming results
//             arbitrate directly. The winner goes out on the CDB at the same
//             edge without passing through a holding register.
//
//  Ports    : clock      - system clock
//             reset      - synchronous, active-low reset
//             flush      - discard all held and outgoing results
//             fu_valid   - [NUM_FU]       FU i presents a result
//             fu_tag     - [NUM_FU*TAG_W] tag of FU i (slice i)
//             fu_value   - [NUM_FU*XLEN]  value of FU i (slice i)
//             fu_ready   - [NUM_FU]       holding register i accepts
//             cdb_valid  - CDB carries a valid broadcast
//             cdb_tag    - broadcast tag (0 when idle)
//             cdb_value  - broadcast value (0 when idle)
//
//  Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 4,
    parameter int XLEN   = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [NUM_FU-1:0]       fu_valid,
    input  logic [NUM_FU*TAG_W-1:0] fu_tag,
    input  logic [NUM_FU*XLEN-1:0]  fu_value,
    output logic [NUM_FU-1:0]       fu_ready,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [XLEN-1:0]         cdb_value
);

    localparam int c_PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    // ------------------------------------------------------------------
    // Input slicing
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]  w_in_tag     [NUM_FU];
    logic [XLEN-1:0]   w_in_value   [NUM_FU];
    logic [NUM_FU-1:0] w_in_nonzero;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_unpack
            assign w_in_tag[gi]     = fu_tag[gi*TAG_W +: TAG_W];
            assign w_in_value[gi]   = fu_value[gi*XLEN +: XLEN];
            assign w_in_nonzero[gi] = (fu_tag[gi*TAG_W +: TAG_W] != '0);
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_FU-1:0]  r_hold_valid;
    logic [TAG_W-1:0]   r_hold_tag   [NUM_FU];
    logic [XLEN-1:0]    r_hold_value [NUM_FU];
    logic [c_PTR_W-1:0] r_rr_ptr;

    // ------------------------------------------------------------------
    // Request vector for the arbiter
    // ------------------------------------------------------------------
    logic [NUM_FU-1:0] w_req;
    logic              w_from_bypass;

`ifdef CDB_ARB_BYPASS_EN
    logic w_any_hold;
    assign w_any_hold = |r_hold_valid;

    // Incoming results compete directly only when nothing is waiting.
    // While any holding register is full, that register has priority.
    // Tag-0 results never compete.
    assign w_from_bypass = !w_any_hold && !flush;
    assign w_req         = w_any_hold    ? r_hold_valid :
                           w_from_bypass ? (fu_valid & w_in_nonzero) : '0;
`else
    assign w_from_bypass = 1'b0;
    assign w_req         = r_hold_valid;
`endif

    // ------------------------------------------------------------------
    // Round-robin arbiter: first requester at or after r_rr_ptr, wrapping
    // ------------------------------------------------------------------
    logic               w_grant_any;
    logic [c_PTR_W-1:0] w_grant_idx;
    logic [NUM_FU-1:0]  w_grant;
    int                 w_scan;

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_grant     = '0;
        w_scan      = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            w_scan = int'(r_rr_ptr) + k;
            if (w_scan >= NUM_FU) begin
                w_scan = w_scan - NUM_FU;
            end
            if (!w_grant_any && w_req[w_scan[c_PTR_W-1:0]]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_scan[c_PTR_W-1:0];
            end
        end
        if (w_grant_any) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    logic [c_PTR_W-1:0] w_next_ptr;
    assign w_next_ptr = (w_grant_idx == c_PTR_W'(NUM_FU - 1)) ? '0
                                                             : w_grant_idx + 1'b1;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // A granted holding register drains at this edge, so it can take a new
    // result in the same cycle. During a flush every result is discarded,
    // so every port may complete its handshake.
    assign fu_ready = flush ? '1 : (~r_hold_valid | w_grant);

    logic [NUM_FU-1:0] w_xfer;
    logic [NUM_FU-1:0] w_byp_grant;
    logic [NUM_FU-1:0] w_load;

    assign w_xfer      = fu_valid & fu_ready;
    assign w_byp_grant = w_from_bypass ? w_grant : '0;

    // A bypass winner is broadcast directly and is not stored.
    assign w_load = w_xfer & w_in_nonzero & ~w_byp_grant;

    // ------------------------------------------------------------------
    // Broadcast source select
    // ------------------------------------------------------------------
    logic [TAG_W-1:0] w_bc_tag;
    logic [XLEN-1:0]  w_bc_value;

    always_comb begin
        w_bc_tag   = r_hold_tag[w_grant_idx];
        w_bc_value = r_hold_value[w_grant_idx];
        if (w_from_bypass) begin
            w_bc_tag   = w_in_tag[w_grant_idx];
            w_bc_value = w_in_value[w_grant_idx];
        end
    end

    // ------------------------------------------------------------------
    // Control state and CDB register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_hold_valid <= '0;
            r_rr_ptr     <= '0;
            cdb_valid    <= 1'b0;
            cdb_tag      <= '0;
            cdb_value    <= '0;
        end else if (flush) begin
            // rr_ptr is kept so that fairness is preserved across squashes.
            r_hold_valid <= '0;
            cdb_valid    <= 1'b0;
            cdb_tag      <= '0;
            cdb_value    <= '0;
        end else begin
            // Clear the drained entry first, then apply any reload. This
            // lets one FU send one result per cycle back to back.
            r_hold_valid <= (r_hold_valid & ~w_grant) | w_load;
            if (w_grant_any) begin
                cdb_valid <= 1'b1;
                cdb_tag   <= w_bc_tag;
                cdb_value <= w_bc_value;
                r_rr_ptr  <= w_next_ptr;
            end else begin
                cdb_valid <= 1'b0;
                cdb_tag   <= '0;
                cdb_value <= '0;
            end
        end
    end

    // Holding payload: only meaningful while the matching valid bit is set,
    // so it needs no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_load[i]) begin
                r_hold_tag[i]   <= w_in_tag[i];
                r_hold_value[i] <= w_in_value[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Self-checking bench for cdb_arbiter with NUM_FU=4, TAG_W=4 and
//             XLEN=32.
//
//             A behavioural model predicts the CDB outputs and fu_ready on
//             every cycle. Directed scenarios add fixed-value expectations
//             for specific cycles.
//
//             The bench also supports the CDB_ARB_BYPASS_EN build option.
//
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int NUM_FU = 4;
    localparam int TAG_W  = 4;
    localparam int XLEN   = 32;

    logic                    clock    = 1'b0;
    logic                    reset    = 1'b0;
    logic                    flush    = 1'b0;
    logic [NUM_FU-1:0]       fu_valid = '0;
    logic [NUM_FU*TAG_W-1:0] fu_tag   = '0;
    logic [NUM_FU*XLEN-1:0]  fu_value = '0;
    logic [NUM_FU-1:0]       fu_ready;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [XLEN-1:0]         cdb_value;

    always #5 clock = ~clock;

    cdb_arbiter #(
        .NUM_FU (NUM_FU),
        .TAG_W  (TAG_W),
        .XLEN   (XLEN)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .fu_valid  (fu_valid),
        .fu_tag    (fu_tag),
        .fu_value  (fu_value),
        .fu_ready  (fu_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: one pending slot per FU, plus a pointer to the FU
    // that is next in line for the bus
    // ------------------------------------------------------------------
    bit               m_hv [NUM_FU];
    logic [TAG_W-1:0] m_ht [NUM_FU];
    logic [XLEN-1:0]  m_hd [NUM_FU];
    int               m_ptr = 0;
    bit               m_cv  = 1'b0;
    logic [TAG_W-1:0] m_ct  = '0;
    logic [XLEN-1:0]  m_cd  = '0;

    logic [TAG_W-1:0] bq_tag [$];
    logic [XLEN-1:0]  bq_val [$];

    task automatic model_step();
        bit                any_pending;
        bit                byp;
        bit                req [NUM_FU];
        int                win;
        int                j;
        logic [NUM_FU-1:0] er;
        logic [TAG_W-1:0]  t;

        any_pending = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            any_pending |= m_hv[i];
        end

        byp = 1'b0;
`ifdef CDB_ARB_BYPASS_EN
        byp = !any_pending && !flush;
`endif

        for (int i = 0; i < NUM_FU; i++) begin
            t      = fu_tag[i*TAG_W +: TAG_W];
            req[i] = any_pending ? m_hv[i] : (byp && fu_valid[i] && (t != 0));
        end

        win = -1;
        for (int k = 0; k < NUM_FU; k++) begin
            j = (m_ptr + k) % NUM_FU;
            if (win < 0 && req[j]) begin
                win = j;
            end
        end

        for (int i = 0; i < NUM_FU; i++) begin
            er[i] = flush || !m_hv[i] || (win == i);
        end
        if (reset) begin
            chk("fu_ready", fu_ready, er);
        end

        if (!reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                m_hv[i] = 1'b0;
            end
            m_ptr = 0;
            m_cv  = 1'b0;
            m_ct  = '0;
            m_cd  = '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                m_hv[i] = 1'b0;
            end
            m_cv = 1'b0;
            m_ct = '0;
            m_cd = '0;
        end else begin
            if (win >= 0) begin
                m_cv = 1'b1;
                if (byp) begin
                    m_ct = fu_tag[win*TAG_W +: TAG_W];
                    m_cd = fu_value[win*XLEN +: XLEN];
                end else begin
                    m_ct = m_ht[win];
                    m_cd = m_hd[win];
                end
                m_ptr = (win + 1) % NUM_FU;
            end else begin
                m_cv = 1'b0;
                m_ct = '0;
                m_cd = '0;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                t = fu_tag[i*TAG_W +: TAG_W];
                if (win == i && !byp) begin
                    m_hv[i] = 1'b0;
                end
                if (fu_valid[i] && er[i] && (t != 0) && !(byp && win == i)) begin
                    m_hv[i] = 1'b1;
                    m_ht[i] = t;
                    m_hd[i] = fu_value[i*XLEN +: XLEN];
                end
            end
        end
    endtask

    // Compare process: samples on the falling edge, once the outputs have
    // settled after the rising edge.
    initial begin
        for (int i = 0; i < NUM_FU; i++) begin
            m_hv[i] = 1'b0;
        end
        @(posedge clock);
        forever begin
            @(negedge clock);
            chk("cdb", {27'd0, cdb_valid, cdb_tag, cdb_value}, {27'd0, m_cv, m_ct, m_cd});
            if (cdb_valid) begin
                bq_tag.push_back(cdb_tag);
                bq_val.push_back(cdb_value);
            end
            model_step();
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_fu(input int i, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
        fu_valid[i]              = 1'b1;
        fu_tag[i*TAG_W +: TAG_W] = t;
        fu_value[i*XLEN +: XLEN] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int                base;
        int                bad;
        int                cnt;
        int                k0;
        int                k2;
        logic [NUM_FU-1:0] xf;
        logic [XLEN-1:0]   v;

        // Reset: held low for two edges, then released
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        chk("rst_cdb_valid", cdb_valid, 1'b0);
        chk("rst_cdb_tag", cdb_tag, 4'd0);
        #1 chk("rst_ready", fu_ready, 4'b1111);
        cyc();

        // Single result
        set_fu(1, 4'd3, 32'hDEAD_BEEF);
        cyc();
        fu_valid = '0;
`ifdef CDB_ARB_BYPASS_EN
        chk("single_n1", {cdb_valid, cdb_tag, cdb_value}, {1'b1, 4'd3, 32'hDEAD_BEEF});
        cyc();
        chk("single_n2", cdb_valid, 1'b0);
`else
        chk("single_n1", cdb_valid, 1'b0);
        cyc();
        chk("single_n2", {cdb_valid, cdb_tag, cdb_value}, {1'b1, 4'd3, 32'hDEAD_BEEF});
`endif
        cyc();
        chk("single_after", cdb_valid, 1'b0);

        // Round-robin from rr_ptr=0
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        base = bq_tag.size();
        for (int i = 0; i < NUM_FU; i++) begin
            set_fu(i, 4'(i + 1), 32'h1111_1111 * (i + 1));
        end
        cyc();
        fu_valid = '0;
        repeat (6) cyc();
        chk("rr_count", bq_tag.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_order%0d", i), bq_tag[base + i], 4'(i + 1));
        end

        // The next contention starts again at FU0
        base = bq_tag.size();
        set_fu(3, 4'd7, 32'h77);
        set_fu(0, 4'd8, 32'h88);
        cyc();
        fu_valid = '0;
        repeat (4) cyc();
        chk("rr_wrap_first", bq_tag[base], 4'd8);
        chk("rr_wrap_second", bq_tag[base + 1], 4'd7);

        // Back-pressure: FU0 and FU2 stream eight results each
        base = bq_val.size();
        k0   = 0;
        k2   = 0;
        for (int c = 0; c < 200 && (k0 < 8 || k2 < 8); c++) begin
            fu_valid = '0;
            if (k0 < 8) begin
                set_fu(0, 4'(k0 + 1), 32'h100 + k0);
            end
            if (k2 < 8) begin
                set_fu(2, (k2 < 7) ? 4'(k2 + 9) : 4'd1, 32'h200 + k2);
            end
            #2;
            xf = fu_valid & fu_ready;
            if (xf[0]) k0++;
            if (xf[2]) k2++;
            cyc();
        end
        chk("bp_sent", k0 + k2, 16);
        fu_valid = '0;
        repeat (6) cyc();
        chk("bp_count", bq_val.size() - base, 16);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            v   = (i < 8) ? 32'h100 + i : 32'h200 + (i - 8);
            cnt = 0;
            for (int q = base; q < bq_val.size(); q++) begin
                if (bq_val[q] == v) cnt++;
            end
            if (cnt != 1) bad++;
        end
        chk("bp_scoreboard", bad, 0);

        // Flush while FU0 and FU2 hold tags 5 and 6
        set_fu(0, 4'd5, 32'h55);
        set_fu(2, 4'd6, 32'h66);
        cyc();
        fu_valid = '0;
        flush    = 1'b1;
        #1 chk("flush_ready", fu_ready, 4'b1111);
        cyc();
        flush = 1'b0;
        base  = bq_tag.size();
        chk("flush_cdb", cdb_valid, 1'b0);
        repeat (5) cyc();
        bad = 0;
        for (int q = base; q < bq_tag.size(); q++) begin
            if (bq_tag[q] == 4'd5 || bq_tag[q] == 4'd6) bad++;
        end
        chk("flush_gone", bad, 0);

        // Tag 0 is dropped
        base = bq_tag.size();
        set_fu(3, 4'd0, 32'h1234);
        repeat (3) begin
            #1 chk("tag0_ready", fu_ready[3], 1'b1);
            cyc();
        end
        fu_valid = '0;
        repeat (4) cyc();
        chk("tag0_none", bq_tag.size() - base, 0);

        // Reset mid-operation loses pending results
        set_fu(1, 4'd9, 32'h99);
        set_fu(2, 4'd10, 32'hAA);
        cyc();
        fu_valid = '0;
        reset    = 1'b0;
        cyc();
        reset = 1'b1;
        base  = bq_tag.size();
        repeat (5) cyc();
        chk("midrst_none", bq_tag.size() - base, 0);
        chk("midrst_cdb", cdb_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
